pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the decode stage of a configurable-depth RISC-V pipeline. It compares decode-stage source registers against the destinations of FWD_STAGES downstream stages and produces per-operand forward selects. It generates multi-cycle load-use stalls and multi-cycle branch flushes, and keeps saturating stall and flush event counters. It replaces the fixed two-operand, single-source forwarding and stall logic in the current core and adds depth, load-use handling and flush sequencing.

## Interface
- AW, 5: register address width.
- FWD_STAGES, 3: number of downstream stages that can forward, legal range 1..4. Stage 1 is the youngest (nearest decode).
- LOAD_STALL, 1: stall cycles per load-use hazard, legal range 1..4.
- FLUSH_CYCLES, 1: flush cycles per taken branch or jump, legal range 1..4.
- SELW, derived: $clog2(FWD_STAGES+1).

- clk  in  1  core clock (the divided clock in the top level).
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  AW each  decode-stage source register addresses.
- id_use_rs1, id_use_rs2  in  1 each  the instruction actually reads that operand.
- st_rd  in  FWD_STAGES*AW  destination address per stage; stage k occupies bits [k*AW-1:(k-1)*AW].
- st_wr  in  FWD_STAGES  the stage writes the register file.
- st_load  in  FWD_STAGES  the stage result comes from data memory and is not yet available.
- br_taken  in  1  decode-stage branch or jump resolved taken.
- fwd_sel_a, fwd_sel_b  out  SELW each  0 = register file; k = forward from stage k.
- stall  out  1  hold PC and the IF/ID register, and insert a bubble into ID/EX.
- flush  out  1  squash the IF/ID register.
- stall_cnt, flush_cnt  out  16 each  saturating event counters.

## Operation
- Match for operand A, stage k: id_use_rs1 && id_rs1 != 0 && st_wr[k-1] && st_rd[k] == id_rs1. Operand B is the same, using rs2.
- fwd_sel_a is the lowest matching k (the youngest producer wins), or 0 if no stage matches. fwd_sel_b is derived the same way. The selects are combinational.
- Load hazard: an operand whose selected stage k has st_load[k-1] = 1. Loads in older stages that are not selected are ignored.
- FSM states are IDLE, STALL and FLUSH. The registered down-counter cnt is 2 bits wide.
- IDLE:
  - A load hazard sets stall = 1 combinationally in that cycle.
  - If LOAD_STALL > 1, the FSM moves to STALL with cnt = LOAD_STALL-2.
  - br_taken is ignored in any cycle where stall = 1.
- IDLE with br_taken and no hazard:
  - flush = 1 combinationally.
  - If FLUSH_CYCLES > 1, the FSM moves to FLUSH with cnt = FLUSH_CYCLES-2.
- STALL:
  - stall = 1 and hazard detection is masked.
  - When cnt = 0 the FSM returns to IDLE; otherwise cnt decrements.
  - fwd_sel outputs still track their inputs.
- FLUSH:
  - flush = 1 and br_taken is ignored.
  - When cnt = 0 the FSM returns to IDLE; otherwise cnt decrements.
  - A load hazard during FLUSH does not assert stall, because the instruction is being squashed.
- stall and flush are never both 1 in the same cycle. When both would assert, stall wins.
- Counters:
  - stall_cnt increments once per cycle with stall = 1.
  - flush_cnt increments once per cycle with flush = 1.
  - Both saturate at 16'hFFFF.

## Timing
- Reset: on a clk edge with rst = 1, state goes to IDLE, cnt = 0 and both counters = 0.
  - While rst = 1: stall = 0, flush = 0, fwd_sel_a = fwd_sel_b = 0, forced combinationally.
  - Reset during STALL or FLUSH aborts the sequence. The first cycle after reset is evaluated from IDLE.
- Forward-select latency: 0 cycles, valid in the same cycle as its inputs.
- Load-use stall: high for exactly LOAD_STALL consecutive cycles starting in the detection cycle. Detection is re-evaluated in the first IDLE cycle afterwards, so back-to-back hazards give back-to-back stalls.
- Branch flush: high for exactly FLUSH_CYCLES consecutive cycles starting in the resolution cycle.
- Counters: updated at the clk edge that ends the counted cycle, so they are visible one cycle after the event.
- Register x0 never matches, whatever st_wr says.

## Test plan
1. Forward priority. Defaults; id_rs1 = 5, id_use_rs1 = 1; st_wr = 3'b111; st_rd = {5, 5, 5}. Required: fwd_sel_a = 1, stall = 0. Then clear st_wr[0]. Required: fwd_sel_a = 2.
2. x0 and unused operand.
   - id_rs2 = 0, with stage 1 writing rd = 0. Required: fwd_sel_b = 0.
   - id_rs2 = 7, id_use_rs2 = 0, with stage 1 writing rd = 7. Required: fwd_sel_b = 0.
3. Multi-cycle load-use. LOAD_STALL = 3; stage 1 is a load with rd = 9; id_rs2 = 9. Required: stall = 1 for exactly 3 cycles, then 0 once st_load[0] clears. stall_cnt = 3 afterwards.
4. Flush with a simultaneous stall.
   - FLUSH_CYCLES = 2; br_taken = 1 in the same cycle as a load hazard. Required: stall = 1, flush = 0.
   - Next cycle, with the hazard gone and br_taken = 1. Required: flush = 1 for 2 cycles, flush_cnt = 2.
5. Reset mid-stall. LOAD_STALL = 4; assert rst in the second stall cycle. Required: all outputs 0 while rst = 1, counters 0, and IDLE on release.
6. Saturation. Preload by holding a hazard for 65 540 cycles. Required: stall_cnt = 16'hFFFF, with no wrap.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard and forwarding controller: per-operand forward selects,
// multi-cycle load-use stalls, multi-cycle branch flushes and saturating event counters.
module pipe_hazard_ctrl #(
    parameter int unsigned AW           = 5,
    parameter int unsigned FWD_STAGES   = 3,
    parameter int unsigned LOAD_STALL   = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned SELW         = $clog2(FWD_STAGES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AW-1:0]              id_rs1,
    input  logic [AW-1:0]              id_rs2,
    input  logic                       id_use_rs1,
    input  logic                       id_use_rs2,
    input  logic [FWD_STAGES*AW-1:0]   st_rd,
    input  logic [FWD_STAGES-1:0]      st_wr,
    input  logic [FWD_STAGES-1:0]      st_load,
    input  logic                       br_taken,
    output logic [SELW-1:0]            fwd_sel_a,
    output logic [SELW-1:0]            fwd_sel_b,
    output logic                       stall,
    output logic                       flush,
    output logic [15:0]                stall_cnt,
    output logic [15:0]                flush_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] STALL_INIT = 2'((LOAD_STALL > 1) ? LOAD_STALL - 2 : 0);
    localparam logic [1:0] FLUSH_INIT = 2'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

    state_t          state;
    logic [1:0]      cnt;
    logic [SELW-1:0] sel_a;
    logic [SELW-1:0] sel_b;
    logic            hit_a;
    logic            hit_b;
    logic            load_a;
    logic            load_b;
    logic            hazard;

    // Ascending scan with a first-hit guard so the youngest producer wins.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        hit_a  = 1'b0;
        hit_b  = 1'b0;
        load_a = 1'b0;
        load_b = 1'b0;
        for (int unsigned k = 0; k < FWD_STAGES; k++) begin
            if (!hit_a && id_use_rs1 && (id_rs1 != '0) && st_wr[k]
                && (st_rd[k*AW +: AW] == id_rs1)) begin
                hit_a  = 1'b1;
                sel_a  = SELW'(k + 1);
                load_a = st_load[k];
            end
            if (!hit_b && id_use_rs2 && (id_rs2 != '0) && st_wr[k]
                && (st_rd[k*AW +: AW] == id_rs2)) begin
                hit_b  = 1'b1;
                sel_b  = SELW'(k + 1);
                load_b = st_load[k];
            end
        end
        hazard = load_a | load_b;
    end

    always_comb begin
        fwd_sel_a = rst ? '0 : sel_a;
        fwd_sel_b = rst ? '0 : sel_b;
        stall     = !rst && ((state == STALL) || ((state == IDLE) && hazard));
        flush     = !rst && ((state == FLUSH) || ((state == IDLE) && !hazard && br_taken));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hazard) begin
                        if (LOAD_STALL > 1) begin
                            state <= STALL;
                            cnt   <= STALL_INIT;
                        end
                    end else if (br_taken && (FLUSH_CYCLES > 1)) begin
                        state <= FLUSH;
                        cnt   <= FLUSH_INIT;
                    end
                end
                STALL, FLUSH: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three parameter sets share one stimulus stream and are
// checked against a cycle-count reference model, a directed vector table and hand sequences.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2;
    logic [14:0] st_rd;
    logic [2:0]  st_wr, st_load;
    logic        br_taken;

    logic [1:0]  sel_a [3];
    logic [1:0]  sel_b [3];
    logic        stall_o [3];
    logic        flush_o [3];
    logic [15:0] scnt [3];
    logic [15:0] fcnt [3];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    int unsigned rem_s [3];
    int unsigned rem_f [3];
    int unsigned m_scnt [3];
    int unsigned m_fcnt [3];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.AW(5), .FWD_STAGES(3), .LOAD_STALL(3), .FLUSH_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .st_rd(st_rd), .st_wr(st_wr),
        .st_load(st_load), .br_taken(br_taken), .fwd_sel_a(sel_a[0]), .fwd_sel_b(sel_b[0]),
        .stall(stall_o[0]), .flush(flush_o[0]), .stall_cnt(scnt[0]), .flush_cnt(fcnt[0]));

    pipe_hazard_ctrl #(.AW(5), .FWD_STAGES(3), .LOAD_STALL(4), .FLUSH_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .st_rd(st_rd), .st_wr(st_wr),
        .st_load(st_load), .br_taken(br_taken), .fwd_sel_a(sel_a[1]), .fwd_sel_b(sel_b[1]),
        .stall(stall_o[1]), .flush(flush_o[1]), .stall_cnt(scnt[1]), .flush_cnt(fcnt[1]));

    pipe_hazard_ctrl #(.AW(5), .FWD_STAGES(3), .LOAD_STALL(1), .FLUSH_CYCLES(4)) dut_c (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .st_rd(st_rd), .st_wr(st_wr),
        .st_load(st_load), .br_taken(br_taken), .fwd_sel_a(sel_a[2]), .fwd_sel_b(sel_b[2]),
        .stall(stall_o[2]), .flush(flush_o[2]), .stall_cnt(scnt[2]), .flush_cnt(fcnt[2]));

    typedef struct {
        logic        rst;
        logic [4:0]  rs1, rs2;
        logic        u1, u2;
        logic [14:0] rd;
        logic [2:0]  wr, ld;
        logic        br;
        logic [1:0]  ea, eb;
        logic        es, ef;
    } vec_t;

    vec_t vec [23];

    function automatic int unsigned cfg_ls(input int unsigned i);
        return (i == 0) ? 3 : (i == 1) ? 4 : 1;
    endfunction

    function automatic int unsigned cfg_fc(input int unsigned i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 4;
    endfunction

    function automatic vec_t mk(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd3,
                                input logic [4:0] rd2, input logic [4:0] rd1,
                                input logic [2:0] wr, input logic [2:0] ld, input logic br,
                                input logic [1:0] ea, input logic [1:0] eb,
                                input logic es, input logic ef);
        vec_t v;
        v.rst = r;  v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.rd = {rd3, rd2, rd1}; v.wr = wr; v.ld = ld; v.br = br;
        v.ea = ea; v.eb = eb; v.es = es; v.ef = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
        st_rd = v.rd; st_wr = v.wr; st_load = v.ld; br_taken = v.br;
    endtask

    // Youngest stage whose written destination equals a used, nonzero source.
    function automatic int unsigned ref_sel(input logic [4:0] rs, input logic u);
        for (int unsigned k = 1; k <= 3; k++) begin
            if (u && rs != 5'd0 && st_wr[k-1] && st_rd[(k-1)*5 +: 5] == rs) return k;
        end
        return 0;
    endfunction

    task automatic tick(input logic use_exp, input vec_t v);
        int unsigned ea, eb;
        logic hz, es, ef;
        @(negedge clk);
        ea = rst ? 0 : ref_sel(id_rs1, id_use_rs1);
        eb = rst ? 0 : ref_sel(id_rs2, id_use_rs2);
        hz = (ea != 0 && st_load[ea-1]) || (eb != 0 && st_load[eb-1]);
        if (use_exp) begin
            check("vec_sel_a", 32'(sel_a[0]), 32'(v.ea));
            check("vec_sel_b", 32'(sel_b[0]), 32'(v.eb));
            check("vec_stall", 32'(stall_o[0]), 32'(v.es));
            check("vec_flush", 32'(flush_o[0]), 32'(v.ef));
        end
        for (int unsigned i = 0; i < 3; i++) begin
            es = 1'b0;
            ef = 1'b0;
            if (!rst) begin
                if (rem_s[i] > 0)      es = 1'b1;
                else if (rem_f[i] > 0) ef = 1'b1;
                else if (hz)           es = 1'b1;
                else if (br_taken)     ef = 1'b1;
            end
            check($sformatf("sel_a[%0d]", i), 32'(sel_a[i]), ea);
            check($sformatf("sel_b[%0d]", i), 32'(sel_b[i]), eb);
            check($sformatf("stall[%0d]", i), 32'(stall_o[i]), 32'(es));
            check($sformatf("flush[%0d]", i), 32'(flush_o[i]), 32'(ef));
            check($sformatf("stall_cnt[%0d]", i), 32'(scnt[i]), m_scnt[i]);
            check($sformatf("flush_cnt[%0d]", i), 32'(fcnt[i]), m_fcnt[i]);
            if (rst) begin
                rem_s[i] = 0; rem_f[i] = 0; m_scnt[i] = 0; m_fcnt[i] = 0;
            end else begin
                if (rem_s[i] > 0)      rem_s[i]--;
                else if (rem_f[i] > 0) rem_f[i]--;
                else if (hz)           rem_s[i] = cfg_ls(i) - 1;
                else if (br_taken)     rem_f[i] = cfg_fc(i) - 1;
                if (es && m_scnt[i] < 65535) m_scnt[i]++;
                if (ef && m_fcnt[i] < 65535) m_fcnt[i]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t hz_v;
        vec[0]  = mk(1, 5, 0, 1, 0, 5, 5, 5, 3'b111, 3'b000, 0, 0, 0, 0, 0);
        vec[1]  = mk(0, 5, 0, 1, 0, 5, 5, 5, 3'b111, 3'b000, 0, 1, 0, 0, 0);
        vec[2]  = mk(0, 5, 0, 1, 0, 5, 5, 5, 3'b110, 3'b000, 0, 2, 0, 0, 0);
        vec[3]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 3'b001, 3'b000, 0, 0, 0, 0, 0);
        vec[4]  = mk(0, 0, 7, 0, 0, 0, 0, 7, 3'b001, 3'b000, 0, 0, 0, 0, 0);
        vec[5]  = mk(0, 0, 7, 0, 1, 0, 0, 7, 3'b001, 3'b000, 0, 0, 1, 0, 0);
        vec[6]  = mk(0, 0, 9, 0, 1, 0, 0, 9, 3'b001, 3'b001, 0, 0, 1, 1, 0);
        vec[7]  = vec[6];
        vec[8]  = vec[6];
        vec[9]  = mk(0, 0, 9, 0, 1, 0, 0, 9, 3'b001, 3'b000, 0, 0, 1, 0, 0);
        vec[10] = mk(0, 0, 9, 0, 1, 0, 0, 9, 3'b001, 3'b001, 1, 0, 1, 1, 0);
        vec[11] = mk(0, 0, 9, 0, 1, 0, 0, 9, 3'b001, 3'b000, 1, 0, 1, 1, 0);
        vec[12] = vec[11];
        vec[13] = mk(0, 0, 9, 0, 1, 0, 0, 9, 3'b001, 3'b000, 1, 0, 1, 0, 1);
        vec[14] = mk(0, 0, 9, 0, 1, 0, 0, 9, 3'b001, 3'b000, 0, 0, 1, 0, 1);
        vec[15] = mk(0, 0, 9, 0, 1, 0, 0, 9, 3'b001, 3'b000, 0, 0, 1, 0, 0);
        vec[16] = mk(0, 0, 9, 0, 1, 0, 9, 9, 3'b011, 3'b010, 0, 0, 1, 0, 0);
        vec[17] = mk(0, 0, 9, 0, 1, 0, 0, 9, 3'b001, 3'b000, 1, 0, 1, 0, 1);
        vec[18] = mk(0, 0, 9, 0, 1, 0, 0, 9, 3'b001, 3'b001, 0, 0, 1, 0, 1);
        vec[19] = mk(0, 0, 9, 0, 1, 0, 0, 9, 3'b001, 3'b001, 0, 0, 1, 1, 0);
        vec[20] = vec[19];
        vec[21] = vec[19];
        vec[22] = mk(0, 0, 9, 0, 1, 0, 0, 9, 3'b001, 3'b000, 0, 0, 1, 0, 0);
        hz_v    = vec[6];

        for (int unsigned i = 0; i < 3; i++) begin
            rem_s[i] = 0; rem_f[i] = 0; m_scnt[i] = 0; m_fcnt[i] = 0;
        end

        for (int unsigned i = 0; i < 23; i++) begin
            apply(vec[i]);
            if (i == 10) check("stall_cnt_after_load_use", 32'(scnt[0]), 32'd3);
            if (i == 16) check("flush_cnt_after_branch", 32'(fcnt[0]), 32'd2);
            tick(1'b1, vec[i]);
        end

        // Reset asserted in the second cycle of a load-use stall.
        apply(hz_v);
        tick(1'b0, hz_v);
        rst = 1'b1;
        tick(1'b0, hz_v);
        tick(1'b0, hz_v);
        for (int unsigned i = 0; i < 3; i++) begin
            check($sformatf("rst_stall_cnt[%0d]", i), 32'(scnt[i]), 32'd0);
            check($sformatf("rst_flush_cnt[%0d]", i), 32'(fcnt[i]), 32'd0);
        end
        rst = 1'b0;
        st_load = 3'b000;
        tick(1'b0, hz_v);

        // Saturation: a hazard held long enough to overrun 16 bits.
        apply(hz_v);
        for (int unsigned n = 0; n < 65540; n++) tick(1'b0, hz_v);
        for (int unsigned i = 0; i < 3; i++)
            check($sformatf("stall_cnt_saturated[%0d]", i), 32'(scnt[i]), 32'h0000_FFFF);

        for (int unsigned n = 0; n < 2000; n++) begin
            rst        = ($urandom_range(63) == 0);
            id_rs1     = 5'($urandom_range(3));
            id_rs2     = 5'($urandom_range(3));
            id_use_rs1 = 1'($urandom_range(1));
            id_use_rs2 = 1'($urandom_range(1));
            st_rd      = {5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3))};
            st_wr      = 3'($urandom_range(7));
            st_load    = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'b000;
            br_taken   = ($urandom_range(3) == 0);
            tick(1'b0, hz_v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
